// File: rtl/adder_pkg.sv
// Shared definitions for the adder result collector slice.
//   DEF_WIDTH / DEF_DEPTH : default operand width and result FIFO depth
//   clog2()               : ceiling log2 usable in parameter expressions
//   Stored FIFO entry layout is {carry, sum[WIDTH-1:0]}, so the entry width
//   is WIDTH+1 with the carry in the top bit.
package adder_pkg;

   localparam int DEF_WIDTH = 3;
   localparam int DEF_DEPTH = 4;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic int entry_w(input int width);
      return width + 1;
   endfunction

endpackage

// File: rtl/adder_result_collector_if.sv
// Handshake bundle between the upstream issuer, the adder outputs, the
// collector and the result consumer.
//   en, issue, issue_ready : pipeline advance, operand-issue strobe, credit
//   s, carry               : adder result outputs
//   m_valid/m_ready/m_sum/m_carry : buffered result stream
//   count, drop_err        : FIFO occupancy, sticky issue-without-credit flag
// master = environment side (issuer + consumer), slave = collector.
interface adder_result_collector_if
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
);
   localparam int CW = clog2(DEPTH + 1);

   logic             en;
   logic             issue;
   logic             issue_ready;
   logic [WIDTH-1:0] s;
   logic             carry;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_sum;
   logic             m_carry;
   logic [CW-1:0]    count;
   logic             drop_err;

   modport master (
      output en, issue, s, carry, m_ready,
      input  issue_ready, m_valid, m_sum, m_carry, count, drop_err
   );

   modport slave (
      input  en, issue, s, carry, m_ready,
      output issue_ready, m_valid, m_sum, m_carry, count, drop_err
   );

endinterface

// File: rtl/fully_pipelined_adder.sv
// Pipelined a+b+c adder. Operands sampled on an enabled edge appear on
// s/carry after LATENCY enabled edges (the sampling edge counts as the first).
// Ports: clk, rst (async high), en (advance), a, b, c (carry-in), s, carry.
module fully_pipelined_adder #(
   parameter int WIDTH   = 3,
   parameter int LATENCY = WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   output logic [WIDTH-1:0] s,
   output logic             carry
);

   logic [WIDTH:0] pipe_q [LATENCY];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
      end else if (en) begin
         pipe_q[0] <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
         for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign s     = pipe_q[LATENCY-1][WIDTH-1:0];
   assign carry = pipe_q[LATENCY-1][WIDTH];

endmodule

// File: rtl/result_fifo.sv
// Synchronous FIFO holding adder results.
//   push_i/wdata_i : write port (caller guarantees no overflow)
//   pop_i          : read advance, ignored when empty
//   rdata_o        : entry at the read pointer
//   count_o, empty_o : occupancy
module result_fifo
   import adder_pkg::*;
#(
   parameter  int DW    = DEF_WIDTH + 1,
   parameter  int DEPTH = DEF_DEPTH,
   localparam int AW    = clog2(DEPTH),
   localparam int CW    = clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o,
   output logic [CW-1:0] count_o,
   output logic          empty_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          pop_ok;

   assign empty_o = (count_q == '0);
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers are exactly log2(DEPTH) bits so they wrap for free.
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_i, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; count gates whether an entry is meaningful.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/adder_result_collector.sv
// Follows each issued operand set through the adder with a one-hot-per-slot
// tag pipe and captures {carry,s} into a result FIFO when its tag reaches the
// last slot. Credits count both buffered and in-flight results, so a capture
// can never find the FIFO full.
// Ports: clk, rst (async high), bus (slave side of the collector interface).
module adder_result_collector
   import adder_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int LATENCY = WIDTH,
   parameter int DEPTH   = DEF_DEPTH
) (
   input  logic clk,
   input  logic rst,
   adder_result_collector_if.slave bus
);

   localparam int DW = entry_w(WIDTH);
   localparam int CW = clog2(DEPTH + 1);

   logic [LATENCY:1] tag_q, tag_d;
   logic             drop_q, drop_d;
   logic [DW-1:0]    hold_q, hold_d;

   logic             issue_ready;
   logic             accept;
   logic             drop;
   logic             push;
   logic             pop;
   logic [31:0]      occ;
   logic [DW-1:0]    fifo_rdata;
   logic [CW-1:0]    fifo_count;
   logic             fifo_empty;

   // Credit check sees registers only, never the incoming issue.
   always_comb begin
      occ = 32'(fifo_count);
      for (int i = 1; i <= LATENCY; i++) occ = occ + 32'(tag_q[i]);
      issue_ready = (occ < 32'(DEPTH));
   end

   always_comb begin
      accept = bus.issue && bus.en && issue_ready;
      drop   = bus.issue && bus.en && !issue_ready;
      // Last slot set means s/carry currently hold that result, whatever en is.
      push   = tag_q[LATENCY];
      pop    = bus.m_ready && !fifo_empty;
      tag_d  = tag_q;
      if (bus.en) begin
         for (int i = LATENCY; i >= 2; i--) tag_d[i] = tag_q[i-1];
         tag_d[1] = accept;
      end else begin
         // Adder is frozen; only the slot just captured is retired so it is
         // not pushed a second time.
         tag_d[LATENCY] = 1'b0;
      end
      drop_d = drop_q | drop;
      // Output shows the FIFO head while valid and otherwise keeps the last one.
      hold_d = fifo_empty ? hold_q : fifo_rdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_q  <= '0;
         drop_q <= 1'b0;
         hold_q <= '0;
      end else begin
         tag_q  <= tag_d;
         drop_q <= drop_d;
         hold_q <= hold_d;
      end
   end

   result_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({bus.carry, bus.s}),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .empty_o (fifo_empty)
   );

   assign bus.issue_ready = issue_ready;
   assign bus.m_valid     = !fifo_empty;
   assign bus.m_sum       = hold_d[WIDTH-1:0];
   assign bus.m_carry     = hold_d[WIDTH];
   assign bus.count       = fifo_count;
   assign bus.drop_err    = drop_q;

endmodule
